// File: rtl/serial_frame_deserializer.sv
// Serial frame deserializer: hunts for SYNC_WORD, then collects WIDTH data bits MSB-first into a valid/ready holding register.
// Optional even-parity bit after the data when SERIAL_FRAME_PARITY_CHECK_EN is defined.
module serial_frame_deserializer #(
    parameter int                  WIDTH     = 8,
    parameter int                  SYNC_LEN  = 8,
    parameter logic [SYNC_LEN-1:0] SYNC_WORD = 8'hA5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             din,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             parity_err,
    output logic             overflow,
    output logic [15:0]      frame_cnt
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {HUNT, DATA, PARITY} state_t;

    state_t              state, next_state;
    logic [SYNC_LEN-2:0] hunt_sr;
    logic [SYNC_LEN-1:0] hunt_full;
    logic [WIDTH-1:0]    data_sr;
    logic [WIDTH-1:0]    word;
    logic [CW-1:0]       bit_cnt;
    logic                sync_hit;
    logic                last_bit;
    logic                complete;

    assign hunt_full = {hunt_sr, din};
    assign sync_hit  = (hunt_full == SYNC_WORD);
    assign last_bit  = (state == DATA) && (bit_cnt == CW'(WIDTH - 1));

`ifdef SERIAL_FRAME_PARITY_CHECK_EN
    assign complete = (state == PARITY);
    assign word     = data_sr;
`else
    assign complete = last_bit;
    assign word     = {data_sr[WIDTH-2:0], din};
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= HUNT;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            HUNT:   if (sync_hit) next_state = DATA;
`ifdef SERIAL_FRAME_PARITY_CHECK_EN
            DATA:   if (last_bit) next_state = PARITY;
`else
            DATA:   if (last_bit) next_state = HUNT;
`endif
            PARITY: next_state = HUNT;
            default: next_state = HUNT;
        endcase
    end

    // Serial datapath: hunt shifter, data shifter and bit counter
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hunt_sr <= '0;
            data_sr <= '0;
            bit_cnt <= '0;
        end else begin
            case (state)
                HUNT: begin
                    hunt_sr <= hunt_full[SYNC_LEN-2:0];
                    bit_cnt <= '0;
                end
                DATA: begin
                    data_sr <= {data_sr[WIDTH-2:0], din};
                    bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
                end
                default: ;
            endcase
            // Clearing on exit keeps a sync pattern from overlapping the data just received
            if (complete) hunt_sr <= '0;
        end
    end

    // Holding register: a completed word loads only if the slot is empty or being drained this cycle
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            overflow   <= 1'b0;
            frame_cnt  <= '0;
`ifdef SERIAL_FRAME_PARITY_CHECK_EN
            parity_err <= 1'b0;
`endif
        end else if (complete) begin
            if (!dout_valid || dout_ready) begin
                dout       <= word;
                dout_valid <= 1'b1;
                frame_cnt  <= frame_cnt + 16'd1;
`ifdef SERIAL_FRAME_PARITY_CHECK_EN
                parity_err <= ^{data_sr, din};
`endif
            end else begin
                overflow <= 1'b1;
            end
        end else if (dout_valid && dout_ready) begin
            dout_valid <= 1'b0;
        end
    end

`ifndef SERIAL_FRAME_PARITY_CHECK_EN
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_frame_deserializer.sv
// Bench for serial_frame_deserializer: streams are parsed into frames by a stream-level model,
// then outputs are compared every cycle and delivered words are scoreboarded.
module tb_serial_frame_deserializer;

    localparam int         W    = 8;
    localparam logic [7:0] SYNC = 8'hA5;
`ifdef SERIAL_FRAME_PARITY_CHECK_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    logic         clock = 1'b0;
    logic         reset;
    logic         din;
    logic         dout_ready;
    logic [W-1:0] dout;
    logic         dout_valid;
    logic         parity_err;
    logic         overflow;
    logic [15:0]  frame_cnt;

    serial_frame_deserializer #(.WIDTH(W), .SYNC_LEN(8), .SYNC_WORD(SYNC)) dut (
        .clock      (clock),
        .reset      (reset),
        .din        (din),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .parity_err (parity_err),
        .overflow   (overflow),
        .frame_cnt  (frame_cnt)
    );

    always #5 clock = ~clock;

    int           n_vec = 0;
    int           n_err = 0;
    logic [W-1:0] exp_q[$];
    bit           stim_b[$];
    bit           stim_r[$];
    bit           comp[];
    logic [W-1:0] cword[];
    bit           cperr[];

    logic [W-1:0] m_dout;
    bit           m_valid, m_ovf, m_perr;
    logic [15:0]  m_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) stim_b.push_back(b[i]);
    endtask

    task automatic push_frame(input logic [7:0] d, input bit par);
        push_byte(SYNC);
        push_byte(d);
        if (PB == 1) stim_b.push_back(par);
    endtask

    // mode 0: never ready, 1: always ready, 2: 50%, 3: rarely ready
    task automatic fill_ready(input int mode);
        stim_r.delete();
        for (int i = 0; i < stim_b.size(); i++) begin
            case (mode)
                0: stim_r.push_back(1'b0);
                1: stim_r.push_back(1'b1);
                2: stim_r.push_back(bit'($urandom_range(0, 1)));
                default: stim_r.push_back($urandom_range(0, 7) == 0);
            endcase
        end
    endtask

    // Stream-level view: find each sync, take the following W (+parity) bits, mark the completion cycle
    task automatic parse();
        int           n, t, e;
        logic [7:0]   win;
        logic [W-1:0] wd;
        bit           p;
        n = stim_b.size();
        comp = new[n];
        cword = new[n];
        cperr = new[n];
        win = '0;
        t = 0;
        while (t < n) begin
            win = {win[6:0], stim_b[t]};
            if (win == SYNC) begin
                e = t + W + PB;
                if (e >= n) break;
                wd = '0;
                for (int i = 1; i <= W; i++) wd = {wd[W-2:0], stim_b[t+i]};
                p = ^wd;
                if (PB == 1) p = p ^ stim_b[t+W+1];
                comp[e] = 1'b1;
                cword[e] = wd;
                cperr[e] = p;
                win = '0;
                t = e + 1;
            end else begin
                t++;
            end
        end
    endtask

    task automatic compare_outputs();
        check("dout", dout, m_dout);
        check("dout_valid", dout_valid, m_valid);
        check("overflow", overflow, m_ovf);
        check("frame_cnt", frame_cnt, m_cnt);
        check("parity_err", parity_err, m_perr);
    endtask

    task automatic model_reset();
        m_dout = '0; m_valid = 0; m_ovf = 0; m_perr = 0; m_cnt = '0;
        exp_q.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1; din = 1'b0; dout_ready = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic run_stream();
        parse();
        for (int t = 0; t < stim_b.size(); t++) begin
            @(negedge clock);
            compare_outputs();
            din = stim_b[t];
            dout_ready = stim_r[t];
            if (m_valid && stim_r[t]) begin
                if (exp_q.size() == 0) check("consume_q_empty", 1, 0);
                else check("consume", dout, exp_q.pop_front());
            end
            if (comp[t]) begin
                if (!m_valid || stim_r[t]) begin
                    m_dout = cword[t]; m_valid = 1; m_cnt++;
                    m_perr = (PB == 1) ? cperr[t] : 1'b0;
                    exp_q.push_back(cword[t]);
                end else begin
                    m_ovf = 1;
                end
            end else if (m_valid && stim_r[t]) begin
                m_valid = 0;
            end
        end
        @(negedge clock);
        compare_outputs();
        dout_ready = 1'b0;
        din = 1'b0;
        stim_b.delete();
        stim_r.delete();
    endtask

    initial begin
        // Reset values
        do_reset();
        check("rst_dout", dout, 0);
        check("rst_valid", dout_valid, 0);
        check("rst_cnt", frame_cnt, 0);
        check("rst_ovf", overflow, 0);
        check("rst_perr", parity_err, 0);

        // Single frame, always ready: one-cycle valid pulse
        push_frame(8'h3C, 1'b0); push_byte(8'h00);
        fill_ready(1);
        run_stream();
        check("s1_dout", dout, 8'h3C);
        check("s1_cnt", frame_cnt, 1);
        check("s1_ovf", overflow, 0);

        // Held word until ready
        do_reset();
        push_byte(8'h00); push_frame(8'hFF, 1'b0); push_byte(8'h00);
        fill_ready(0);
        stim_r[28+PB] = 1'b1;
        run_stream();
        check("s2_dout", dout, 8'hFF);
        check("s2_valid", dout_valid, 0);
        check("s2_cnt", frame_cnt, 1);

        // Overflow; data byte equal to sync must not re-sync
        do_reset();
        push_frame(8'h11, 1'b0); push_frame(8'h22, 1'b0); push_frame(8'hA5, 1'b0); push_byte(8'h00);
        fill_ready(0);
        run_stream();
        check("s3_dout", dout, 8'h11);
        check("s3_ovf", overflow, 1);
        check("s3_cnt", frame_cnt, 1);

        // Back-to-back with ready pulsed on the second completion
        do_reset();
        push_frame(8'h11, 1'b0); push_frame(8'h22, 1'b0);
        fill_ready(0);
        stim_b.push_back(1'b0); stim_r.push_back(1'b0);
        stim_r[31+2*PB] = 1'b1;
        run_stream();
        check("s4_dout", dout, 8'h22);
        check("s4_valid", dout_valid, 1);
        check("s4_ovf", overflow, 0);
        check("s4_cnt", frame_cnt, 2);

        // Reset mid-frame
        do_reset();
        push_frame(8'h3C, 1'b0); push_byte(8'hA5);
        for (int i = 0; i < 4; i++) stim_b.push_back(i < 2);
        fill_ready(0);
        run_stream();
        @(negedge clock);
        #2 reset = 1'b1;
        #1;
        check("s5_rst_dout", dout, 0);
        check("s5_rst_valid", dout_valid, 0);
        check("s5_rst_cnt", frame_cnt, 0);
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        push_frame(8'h5A, 1'b0); push_byte(8'h00);
        fill_ready(0);
        run_stream();
        check("s5_dout", dout, 8'h5A);
        check("s5_cnt", frame_cnt, 1);

`ifdef SERIAL_FRAME_PARITY_CHECK_EN
        do_reset();
        push_frame(8'h07, 1'b1);
        fill_ready(0);
        run_stream();
        check("par_ok_dout", dout, 8'h07);
        check("par_ok_err", parity_err, 0);
        do_reset();
        push_frame(8'h07, 1'b0);
        fill_ready(0);
        run_stream();
        check("par_bad_dout", dout, 8'h07);
        check("par_bad_err", parity_err, 1);
`endif

        // Randomized streams with mixed noise and frames
        for (int r = 0; r < 8; r++) begin
            do_reset();
            for (int k = 0; k < 6; k++) begin
                if ($urandom_range(0, 2) == 0) push_byte(8'($urandom()));
                else push_frame(8'($urandom()), bit'($urandom_range(0, 1)));
            end
            push_byte(8'h00); push_byte(8'h00);
            fill_ready(r % 4);
            run_stream();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
